// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter merging NUM_CH AXI-Stream inputs into one output.
// A grant is held for a whole packet; output passes through a 2-entry register FIFO.
module axis_pkt_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 512,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                           axis_aclk,
  input  logic                           axis_aresetn,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_CH-1:0]              s_tlast,
  input  logic [NUM_CH-1:0]              s_tvalid,
  output logic [NUM_CH-1:0]              s_tready,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic [DATA_WIDTH/8-1:0]        m_tkeep,
  output logic                           m_tlast,
  output logic [CH_W-1:0]                m_tuser,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [31:0]                    stat_pkts,
  output logic                           dbg_state
);

  localparam int KW = DATA_WIDTH / 8;

  // Handshake: a beat moves on any port only in a cycle where tvalid and tready
  // are both 1; tready never depends combinationally on the same port's tvalid.
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state;
  logic [CH_W-1:0] grant;
  logic [CH_W-1:0] last_grant;
  logic [CH_W-1:0] next_grant;
  logic [CH_W-1:0] scan_idx;
  logic            any_req;

  logic [1:0]            obuf_cnt;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [KW-1:0]         buf_keep [2];
  logic                  buf_last [2];
  logic [CH_W-1:0]       buf_ch   [2];

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KW-1:0]         sel_keep;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  room;
  logic                  push;
  logic                  pop;

  // Round-robin scan starting just above the previous packet's channel.
  always_comb begin
    any_req    = 1'b0;
    next_grant = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = CH_W'((int'(last_grant) + 1 + i) % NUM_CH);
      if (!any_req && s_tvalid[scan_idx]) begin
        any_req    = 1'b1;
        next_grant = scan_idx;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant == CH_W'(c)) begin
        sel_data  = s_tdata[c*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_tkeep[c*KW +: KW];
        sel_last  = s_tlast[c];
        sel_valid = s_tvalid[c];
      end
    end
  end

  // Ready depends only on registered state, never on m_tready.
  assign room = (obuf_cnt < 2'd2);

  always_comb begin
    s_tready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      s_tready[c] = (state == LOCKED) && (grant == CH_W'(c)) && room;
    end
  end

  assign push = (state == LOCKED) && sel_valid && room;
  assign pop  = m_tvalid && m_tready;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= next_grant;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (push && sel_last) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      obuf_cnt  <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      stat_pkts <= 32'd0;
      for (int e = 0; e < 2; e++) begin
        buf_data[e] <= '0;
        buf_keep[e] <= '0;
        buf_last[e] <= 1'b0;
        buf_ch[e]   <= '0;
      end
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= sel_data;
        buf_keep[wr_ptr] <= sel_keep;
        buf_last[wr_ptr] <= sel_last;
        buf_ch[wr_ptr]   <= grant;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (buf_last[rd_ptr]) begin
          stat_pkts <= stat_pkts + 32'd1;
        end
      end
      case ({push, pop})
        2'b10:   obuf_cnt <= obuf_cnt + 2'd1;
        2'b01:   obuf_cnt <= obuf_cnt - 2'd1;
        default: obuf_cnt <= obuf_cnt;
      endcase
    end
  end

  // Head entry is never written while valid, so m_* hold steady under stall.
  assign m_tvalid  = (obuf_cnt != 2'd0);
  assign m_tdata   = buf_data[rd_ptr];
  assign m_tkeep   = buf_keep[rd_ptr];
  assign m_tlast   = buf_last[rd_ptr];
  assign m_tuser   = buf_ch[rd_ptr];
  assign dbg_state = (state == LOCKED);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: per-channel packet sources, output beat capture,
// and per-scenario tasks comparing captured beats with hand-computed expectations.
module tb_axis_pkt_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int KW     = DW / 8;
  localparam int CH_W   = 2;
  localparam int SW     = 1 + KW + DW;
  localparam int OW     = CH_W + 1 + KW + DW;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [NUM_CH*DW-1:0]   s_tdata = '0;
  logic [NUM_CH*KW-1:0]   s_tkeep = '0;
  logic [NUM_CH-1:0]      s_tlast = '0;
  logic [NUM_CH-1:0]      s_tvalid = '0;
  logic [NUM_CH-1:0]      s_tready;
  logic [DW-1:0]          m_tdata;
  logic [KW-1:0]          m_tkeep;
  logic                   m_tlast;
  logic [CH_W-1:0]        m_tuser;
  logic                   m_tvalid;
  logic                   m_tready = 1'b1;
  logic [31:0]            stat_pkts;
  logic                   dbg_state;

  axis_pkt_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CH_W(CH_W)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .stat_pkts(stat_pkts), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [SW-1:0]     src_q [NUM_CH][$];
  logic [OW-1:0]     exp_q [$];
  logic [OW-1:0]     obs_q [$];
  int                obs_cyc [$];
  logic [NUM_CH-1:0] in_fire = '0;
  int                in_cnt [NUM_CH] = '{default: 0};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: at the falling edge, record handshakes that the next rising edge completes.
  always @(negedge clk) begin
    in_fire <= s_tvalid & s_tready;
    for (int c = 0; c < NUM_CH; c++) begin
      if (s_tvalid[c] && s_tready[c]) in_cnt[c] <= in_cnt[c] + 1;
    end
    if (m_tvalid && m_tready) begin
      obs_q.push_back({m_tuser, m_tlast, m_tkeep, m_tdata});
      obs_cyc.push_back(cyc);
    end
  end

  // Source driver: present the head beat of each channel queue, pop it once accepted.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_fire[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
        if (src_q[c].size() > 0) begin
          s_tvalid[c] = 1'b1;
          {s_tlast[c], s_tkeep[c*KW +: KW], s_tdata[c*DW +: DW]} = src_q[c][0];
        end else begin
          s_tvalid[c] = 1'b0;
          s_tlast[c]  = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_slot();
    @(posedge clk); #2;
  endtask

  task automatic sample_slot();
    @(negedge clk); #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic push_beat(input int ch, input logic last, input logic [KW-1:0] keep,
                           input logic [DW-1:0] data);
    src_q[ch].push_back({last, keep, data});
  endtask

  task automatic wait_obs(input int n, input string name);
    int t = 0;
    while (obs_q.size() < n && t < 60) begin
      sample_slot();
      t++;
    end
    n_checks++;
    if (obs_q.size() < n) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d beats, need %0d", name, obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) sample_slot();
    n_checks++; if (s_tready !== 4'h0) begin n_fail++; $display("FAIL rst_s_tready got %h exp 0", s_tready); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid got %b exp 0", m_tvalid); end
    n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_m_tlast got %b exp 0", m_tlast); end
    n_checks++; if (m_tuser !== 2'd0) begin n_fail++; $display("FAIL rst_m_tuser got %0d exp 0", m_tuser); end
    n_checks++; if (m_tdata !== 32'h0) begin n_fail++; $display("FAIL rst_m_tdata got %h exp 0", m_tdata); end
    n_checks++; if (m_tkeep !== 4'h0) begin n_fail++; $display("FAIL rst_m_tkeep got %h exp 0", m_tkeep); end
    n_checks++; if (stat_pkts !== 32'h0) begin n_fail++; $display("FAIL rst_stat_pkts got %h exp 0", stat_pkts); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rst_state got %b exp IDLE", dbg_state); end
    drive_slot();
    rst_n = 1'b1;
    sample_slot();
  endtask

  task automatic test_single_packet();
    int t_acc;
    clear_sb();
    drive_slot();
    for (int i = 0; i < 3; i++) begin
      push_beat(0, (i == 2), 4'hF, 32'hA0 + i);
      exp_q.push_back({2'd0, (i == 2), 4'hF, 32'hA0 + i});
    end
    sample_slot();
    sample_slot();
    n_checks++; if (s_tready[0] !== 1'b0) begin n_fail++; $display("FAIL single_arb_cycle s_tready0 got %b exp 0", s_tready[0]); end
    sample_slot();
    t_acc = cyc;
    n_checks++; if (s_tready[0] !== 1'b1) begin n_fail++; $display("FAIL single_grant s_tready0 got %b exp 1", s_tready[0]); end
    n_checks++; if (dbg_state !== 1'b1) begin n_fail++; $display("FAIL single_state got %b exp LOCKED", dbg_state); end
    wait_obs(3, "single");
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_beat%0d got %h exp %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
      n_checks++;
      if (i >= obs_cyc.size() || obs_cyc[i] !== t_acc + 1 + i) begin
        n_fail++; $display("FAIL single_timing%0d got cycle %0d exp %0d", i, (i < obs_cyc.size()) ? obs_cyc[i] : -1, t_acc + 1 + i);
      end
    end
    repeat (3) sample_slot();
    n_checks++; if (stat_pkts !== 32'd1) begin n_fail++; $display("FAIL single_stat got %0d exp 1", stat_pkts); end
    n_checks++; if (obs_q.size() !== 3) begin n_fail++; $display("FAIL single_count got %0d exp 3", obs_q.size()); end
  endtask

  task automatic test_round_robin();
    int c;
    clear_sb();
    drive_slot();
    for (int n = 0; n < 2; n++)
      for (int ch = 0; ch < NUM_CH; ch++) push_beat(ch, 1'b1, 4'(1 << ch), 32'h100 * ch + n);
    // Channel 0 won last, so the scan starts at channel 1.
    for (int p = 0; p < 8; p++) begin
      c = (1 + p) % NUM_CH;
      exp_q.push_back({CH_W'(c), 1'b1, 4'(1 << c), 32'(32'h100 * c + p / 4)});
    end
    wait_obs(8, "rr");
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (p >= obs_q.size() || obs_q[p] !== exp_q[p]) begin
        n_fail++; $display("FAIL rr_beat%0d got %h exp %h", p, (p < obs_q.size()) ? obs_q[p] : '0, exp_q[p]);
      end
      if (p > 0) begin
        n_checks++;
        if (p >= obs_cyc.size() || obs_cyc[p] - obs_cyc[p-1] !== 2) begin
          n_fail++; $display("FAIL rr_gap%0d got %0d exp 2", p, (p < obs_cyc.size()) ? obs_cyc[p] - obs_cyc[p-1] : -1);
        end
      end
    end
    repeat (3) sample_slot();
    n_checks++; if (stat_pkts !== 32'd9) begin n_fail++; $display("FAIL rr_stat got %0d exp 9", stat_pkts); end
  endtask

  task automatic test_no_preempt();
    clear_sb();
    drive_slot();
    for (int i = 0; i < 4; i++) begin
      push_beat(1, (i == 3), 4'hF, 32'hB0 + i);
      exp_q.push_back({2'd1, (i == 3), 4'hF, 32'hB0 + i});
    end
    exp_q.push_back({2'd0, 1'b1, 4'h0, 32'hC0});
    wait_obs(1, "nopre_start");
    drive_slot();
    push_beat(0, 1'b1, 4'h0, 32'hC0);
    wait_obs(5, "nopre");
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL nopre_beat%0d got %h exp %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    repeat (3) sample_slot();
  endtask

  task automatic test_backpressure();
    int base;
    clear_sb();
    base = in_cnt[2];
    drive_slot();
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_beat(2, (i == 3), 4'hF, 32'hD0 + i);
      exp_q.push_back({2'd2, (i == 3), 4'hF, 32'hD0 + i});
    end
    repeat (5) sample_slot();
    n_checks++; if (in_cnt[2] - base !== 2) begin n_fail++; $display("FAIL bp_accepted got %0d exp 2", in_cnt[2] - base); end
    n_checks++; if (s_tready[2] !== 1'b0) begin n_fail++; $display("FAIL bp_s_tready_full got %b exp 0", s_tready[2]); end
    n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_m_tvalid got %b exp 1", m_tvalid); end
    n_checks++; if (m_tdata !== 32'hD0) begin n_fail++; $display("FAIL bp_hold_data got %h exp d0", m_tdata); end
    n_checks++; if (m_tuser !== 2'd2) begin n_fail++; $display("FAIL bp_hold_user got %0d exp 2", m_tuser); end
    drive_slot();
    m_tready = 1'b1;
    wait_obs(4, "bp");
    repeat (4) sample_slot();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_beat%0d got %h exp %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    n_checks++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL bp_count got %0d exp 4", obs_q.size()); end
  endtask

  task automatic test_reset_mid_packet();
    clear_sb();
    drive_slot();
    for (int i = 0; i < 4; i++) push_beat(2, (i == 3), 4'hF, 32'hE0 + i);
    wait_obs(1, "rstmid_start");
    drive_slot();
    rst_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    clear_sb();
    sample_slot();
    n_checks++; if (s_tready !== 4'h0) begin n_fail++; $display("FAIL rstmid_s_tready got %h exp 0", s_tready); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_tvalid got %b exp 0", m_tvalid); end
    n_checks++; if (m_tdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_m_tdata got %h exp 0", m_tdata); end
    n_checks++; if (m_tuser !== 2'd0) begin n_fail++; $display("FAIL rstmid_m_tuser got %0d exp 0", m_tuser); end
    n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_tlast got %b exp 0", m_tlast); end
    n_checks++; if (stat_pkts !== 32'h0) begin n_fail++; $display("FAIL rstmid_stat got %0d exp 0", stat_pkts); end
    drive_slot();
    rst_n = 1'b1;
    push_beat(2, 1'b1, 4'h3, 32'hF2);
    push_beat(0, 1'b1, 4'hC, 32'hF0);
    exp_q.push_back({2'd0, 1'b1, 4'hC, 32'hF0});
    exp_q.push_back({2'd2, 1'b1, 4'h3, 32'hF2});
    wait_obs(2, "rstmid");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rstmid_beat%0d got %h exp %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    repeat (3) sample_slot();
    n_checks++; if (stat_pkts !== 32'd2) begin n_fail++; $display("FAIL rstmid_stat_after got %0d exp 2", stat_pkts); end
    n_checks++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL rstmid_count got %0d exp 2", obs_q.size()); end
  endtask

  task automatic test_stat_wrap();
    clear_sb();
    drive_slot();
    force dut.stat_pkts = 32'hFFFF_FFFF;
    sample_slot();
    release dut.stat_pkts;
    n_checks++; if (stat_pkts !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload got %h exp ffffffff", stat_pkts); end
    drive_slot();
    push_beat(3, 1'b1, 4'h5, 32'h3C);
    exp_q.push_back({2'd3, 1'b1, 4'h5, 32'h3C});
    wait_obs(1, "wrap");
    n_checks++;
    if (obs_q.size() < 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL wrap_beat got %h exp %h", (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
    end
    repeat (3) sample_slot();
    n_checks++; if (stat_pkts !== 32'h0) begin n_fail++; $display("FAIL wrap_stat got %h exp 0", stat_pkts); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_no_preempt();
    test_backpressure();
    test_reset_mid_packet();
    test_stat_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
